// File: rtl/game_flow.sv
// Round sequencer for the bird/pipe control block: start/over FSM, session high score,
// game-over blink and a sequential double-dabble score-to-BCD converter.
module game_flow #(
    parameter int BLINK_HALF = 5,
    parameter int OVER_DWELL = 20
) (
    input  logic        rst,
    input  logic        clk_100ms,
    input  logic        up,
    input  logic        fail,
    input  logic [15:0] score,
    output logic        game_rst_n,
    output logic [1:0]  state,
    output logic [15:0] high_score,
    output logic        new_record,
    output logic        blink,
    output logic [19:0] digits,
    output logic        bcd_busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int DW = (OVER_DWELL > 1) ? $clog2(OVER_DWELL) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(OVER_DWELL - 1);

    state_t         state_q;
    state_t         state_n;
    logic           up_q;
    logic           armed;
    logic           press;
    logic           start_round;
    logic           end_round;
    logic [BW-1:0]  blink_cnt;
    logic [DW-1:0]  dwell_cnt;
    logic [15:0]    src;
    logic [15:0]    last_src;
    logic [35:0]    sh;
    logic [35:0]    sh_adj;
    logic [3:0]     count;

    // armed stays low until up is seen low, so a button held through reset is not a press
    assign press = up & ~up_q & armed;
    assign state = state_q;
    assign src   = (state_q == IDLE) ? high_score : score;

    always_comb begin
        state_n     = state_q;
        start_round = 1'b0;
        end_round   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_n     = PLAY;
                    start_round = 1'b1;
                end
            end
            PLAY: begin
                if (fail) begin
                    state_n   = OVER;
                    end_round = 1'b1;
                end
            end
            OVER: begin
                if (press && (dwell_cnt == DWELL_LAST)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            game_rst_n <= 1'b0;
            up_q       <= 1'b0;
            armed      <= 1'b0;
            high_score <= '0;
            new_record <= 1'b0;
            blink      <= 1'b0;
            blink_cnt  <= '0;
            dwell_cnt  <= '0;
        end else begin
            state_q    <= state_n;
            game_rst_n <= (state_n != IDLE);
            up_q       <= up;
            armed      <= armed | ~up;
            if (start_round) begin
                new_record <= 1'b0;
            end
            if (end_round && (score > high_score)) begin
                high_score <= score;
                new_record <= 1'b1;
            end
            // counters run only while staying in OVER, so they read 0 on the entry edge
            if ((state_q == OVER) && (state_n == OVER)) begin
                if (dwell_cnt != DWELL_LAST) begin
                    dwell_cnt <= dwell_cnt + DW'(1);
                end
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                dwell_cnt <= '0;
                blink_cnt <= '0;
                blink     <= 1'b0;
            end
        end
    end

    // sh[35:16] holds the five BCD nibbles, sh[15:0] the binary bits still to shift in
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < 5; i++) begin
            if (sh[16 + 4*i +: 4] >= 4'd5) begin
                sh_adj[16 + 4*i +: 4] = sh[16 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            sh       <= '0;
            count    <= '0;
            last_src <= '0;
            digits   <= '0;
            bcd_busy <= 1'b0;
        end else if (bcd_busy) begin
            sh    <= {sh_adj[34:0], 1'b0};
            count <= count + 4'd1;
            if (count == 4'd15) begin
                digits   <= sh_adj[34:15];
                bcd_busy <= 1'b0;
            end
        end else if (src != last_src) begin
            sh       <= {20'd0, src};
            last_src <= src;
            count    <= '0;
            bcd_busy <= 1'b1;
        end
    end
endmodule

// File: doc/game_flow.md
# game_flow

Game-sequencing stage downstream of the bird/pipe control block. It consumes that block's `fail` and `score` outputs and drives its active-low reset (`game_rst_n`), so the control block is held in reset until the player starts a round. It also keeps the session high score and flags a new record. It converts the selected score into five BCD digits for the 7-segment/VGA score renderer, using a sequential double-dabble converter.

## Interface
- `BLINK_HALF`, default 5: clk_100ms cycles per half-period of the game-over blink (500 ms).
- `OVER_DWELL`, default 20: minimum number of cycles spent in OVER before a press is accepted (2 s).
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `clk_100ms` input, 1 bit: clock, same 100 ms tick that clocks the control block.
- `up` input, 1 bit: debounced button level, the same debounced signal the control block uses.
- `fail` input, 1 bit: game-over level from the control block.
- `score` input, 16 bits: current score from the control block.
- `game_rst_n` output, 1 bit: registered, active-low reset to the control block.
- `state` output, 2 bits: 0 = IDLE, 1 = PLAY, 2 = OVER; encoding 3 is unused.
- `high_score` output, 16 bits: session high score.
- `new_record` output, 1 bit: the last round beat the previous high score.
- `blink` output, 1 bit: blink phase for the game-over overlay.
- `digits` output, 20 bits: BCD digits of the displayed value, ten-thousands digit in [19:16].
- `bcd_busy` output, 1 bit: a conversion is in progress.

## Operation
- **Press detection:** `up_q` is a registered copy of `up`, reset to 0. `press = up & ~up_q`.
  - If `up` is high when reset releases, no press is seen until `up` falls and rises again.
- **FSM, all transitions on posedge clk_100ms:**
  - IDLE: on `press`, go to PLAY, set `game_rst_n <= 1` and clear `new_record`.
  - PLAY: on `fail == 1`, go to OVER. On that same edge, if `score > high_score`, set `high_score <= score` and `new_record <= 1`; otherwise both are unchanged.
  - PLAY ignores presses; the control block acts on them.
  - OVER: a dwell counter counts 0 up to `OVER_DWELL-1` and saturates there. A `press` is accepted only when the counter equals `OVER_DWELL-1`; it sends the FSM to IDLE with `game_rst_n <= 0`. Presses before that are discarded.
- **game_rst_n:** 0 in IDLE, 1 in PLAY and OVER. It is registered and changes on the same edge as `state`.
- **Blink:** counts only in OVER. The blink counter runs 0 to `BLINK_HALF-1`; at `BLINK_HALF-1` it wraps and `blink` toggles. On entry to OVER, the counter, the dwell counter and `blink` are all 0. Outside OVER, `blink = 0` and the counters are held at 0.
- **Display source:** `src = high_score` in IDLE; `src = score` in PLAY and OVER.
- **BCD converter:**
  - Start: when not busy and `src != last_src`, load the shift register with `src`, set `last_src <= src`, `count <= 0`, `bcd_busy <= 1`.
  - Each busy cycle: add 3 to every BCD nibble that is ≥ 5, then shift left by 1.
  - Finish: after the 16th shift, write the result to `digits` and set `bcd_busy <= 0`.
  - If `src` changes mid-conversion, the current conversion finishes and its result is output. A new conversion then starts on the first non-busy edge.
- **high_score:** persists across rounds and is cleared only by `rst`. It is a 16-bit unsigned compare; a tie does not set `new_record`.

## Timing
- **Reset values:** `state` = IDLE, `game_rst_n` = 0, `high_score` = 0, `new_record` = 0, `blink` = 0, `digits` = 0, `bcd_busy` = 0. Internally, `last_src` = 0, `up_q` = 0 and all counters = 0.
- **Reset mid-operation:** asynchronous. Outputs take their reset values immediately, and any conversion in flight is abandoned.
- **Press latency:** a rising `up` sampled at edge E gives `state`/`game_rst_n` updated at edge E. Both are valid after E.
- **Fail latency:** `fail` sampled at edge E gives OVER, plus `high_score`/`new_record`, updated at E.
- **BCD latency:** a `src` change is seen at load edge E0. There are shifts on E1..E16, and `digits` is valid after E16 (16 edges after the load edge). `bcd_busy` is high from E0 to E16 and low after E16.
- **OVER:** earliest accepted exit is the press sampled at the 20th edge after entry, counting the entry edge as 0. `blink` first toggles `BLINK_HALF` edges after entry.

## Test plan
- **Reset, then start:** `rst` low, then release.
  - Outputs: `game_rst_n = 0`, `state = 0`, `digits = 0`.
  - Raise `up` for 1 cycle: on that edge `state = 1` and `game_rst_n = 1`.
- **BCD conversion:** in PLAY, set `score = 12345`.
  - `bcd_busy` is high for 16 edges.
  - `digits = 0x12345` 16 edges after the load edge.
  - Next, `score = 65535` gives `digits = 0x65535`.
- **Record round:** `high_score = 0`, `score = 7`, assert `fail`.
  - `state = 2`, `high_score = 7`, `new_record = 1`.
  - Second round with `score = 7` and fail: `high_score` stays 7, `new_record = 0`.
- **Dwell and blink:** in OVER, press at cycle 5 and the FSM stays in OVER. `blink` toggles every 5 edges. Press at cycle 20: `state = 0`, `game_rst_n = 0`, `digits` converts to `high_score`.
- **Mid-conversion change:** change `score` 100 → 101 at shift 8.
  - `digits` first shows 0x00100, then 0x00101 after a second conversion. No corrupted intermediate value appears.
- **Async reset in OVER with `up` held high:** all outputs return to reset values. `high_score = 0`. No start occurs until `up` falls and rises.
